// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-type encodings,
// FSM states and the per-type byte-lane footprint.
package lsu_pkg;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ0,
        S_WAIT0,
        S_REQ1,
        S_WAIT1,
        S_DONE
    } state_e;

    // Byte enables of an access at offset 0; all-zero marks an illegal type.
    function automatic logic [3:0] type_be(input logic [2:0] t);
        logic [3:0] be;
        case (t)
            LSU_B, LSU_BU: be = 4'b0001;
            LSU_H, LSU_HU: be = 4'b0011;
            LSU_W:         be = 4'b1111;
            default:       be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic type_legal(input logic [2:0] t);
        return type_be(t) != 4'b0000;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: byte enables and write data for both beats,
// and extraction plus sign/zero extension of the load result.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  op_type,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata0,
    input  logic [31:0] rdata1,
    output logic        split,
    output logic [3:0]  be0,
    output logic [3:0]  be1,
    output logic [31:0] wdata0,
    output logic [31:0] wdata1,
    output logic [31:0] ld_data
);

    logic [3:0]  be_sz;
    logic [31:0] wmask;
    logic [4:0]  sh;
    logic [7:0]  be_wide;
    logic [63:0] wd_wide;
    logic [31:0] ld_word;

    // Two beats viewed as one 64-bit window: beat 1 is simply the upper half.
    always_comb begin
        be_sz   = type_be(op_type);
        wmask   = {{8{be_sz[3]}}, {8{be_sz[2]}}, {8{be_sz[1]}}, {8{be_sz[0]}}};
        sh      = {offset, 3'b000};
        be_wide = {4'b0000, be_sz} << offset;
        wd_wide = {32'h0, wdata & wmask} << sh;
        ld_word = 32'({rdata1, rdata0} >> sh);
        split   = |be_wide[7:4];
        be0     = be_wide[3:0];
        be1     = be_wide[7:4];
        wdata0  = wd_wide[31:0];
        wdata1  = wd_wide[63:32];
        case (op_type)
            LSU_B:   ld_data = {{24{ld_word[7]}}, ld_word[7:0]};
            LSU_H:   ld_data = {{16{ld_word[15]}}, ld_word[15:0]};
            LSU_W:   ld_data = ld_word;
            LSU_BU:  ld_data = {24'h0, ld_word[7:0]};
            LSU_HU:  ld_data = {16'h0, ld_word[15:0]};
            default: ld_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one operation at a time, split into up to two word beats
// on a req/gnt + rvalid memory bus, with a per-beat timeout.
module lsu
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        lsu_valid,
    output logic        lsu_ready,
    input  logic        lsu_we,
    input  logic [2:0]  lsu_type,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    output logic        lsu_done,
    output logic [31:0] lsu_rdata,
    output logic        lsu_err,
    output logic        mem_req,
    input  logic        mem_gnt,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_e        state, state_nx;
    logic          op_we, err_q;
    logic [2:0]    op_type;
    logic [31:0]   op_addr, op_wdata, rd0, rd1;
    logic [CW-1:0] cnt;
    logic          split;
    logic [3:0]    be0, be1;
    logic [31:0]   wd0, wd1, ld_data, word0;
    logic          busy, event_ok, expired;

    lsu_align u_align (
        .op_type (op_type),
        .offset  (op_addr[1:0]),
        .wdata   (op_wdata),
        .rdata0  (rd0),
        .rdata1  (rd1),
        .split   (split),
        .be0     (be0),
        .be1     (be1),
        .wdata0  (wd0),
        .wdata1  (wd1),
        .ld_data (ld_data)
    );

    assign word0    = {op_addr[31:2], 2'b00};
    assign busy     = state inside {S_REQ0, S_WAIT0, S_REQ1, S_WAIT1};
    assign event_ok = ((state == S_REQ0 || state == S_REQ1) && mem_gnt) ||
                      ((state == S_WAIT0 || state == S_WAIT1) && mem_rvalid);
    // The awaited handshake wins over expiry when both land on the last cycle.
    assign expired  = busy && !event_ok && (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (lsu_valid) state_nx = type_legal(lsu_type) ? S_REQ0 : S_DONE;
            S_REQ0:  if (mem_gnt) state_nx = S_WAIT0;
            S_WAIT0: if (mem_rvalid) state_nx = split ? S_REQ1 : S_DONE;
            S_REQ1:  if (mem_gnt) state_nx = S_WAIT1;
            S_WAIT1: if (mem_rvalid) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        if (expired) state_nx = S_DONE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_we    <= 1'b0;
            op_type  <= 3'b000;
            op_addr  <= 32'h0;
            op_wdata <= 32'h0;
            err_q    <= 1'b0;
            rd0      <= 32'h0;
            rd1      <= 32'h0;
            cnt      <= '0;
        end else begin
            if (state == S_IDLE && lsu_valid) begin
                op_we    <= lsu_we;
                op_type  <= lsu_type;
                op_addr  <= lsu_addr;
                op_wdata <= lsu_wdata;
                err_q    <= !type_legal(lsu_type);
            end
            if (expired) err_q <= 1'b1;
            if (state == S_WAIT0 && mem_rvalid) rd0 <= mem_rdata;
            if (state == S_WAIT1 && mem_rvalid) rd1 <= mem_rdata;
            // The budget covers both the grant and the response of one beat.
            if (state_nx != state && (state_nx == S_REQ0 || state_nx == S_REQ1))
                cnt <= '0;
            else if (busy)
                cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        lsu_ready = (state == S_IDLE);
        lsu_done  = (state == S_DONE);
        lsu_err   = lsu_done && err_q;
        lsu_rdata = (lsu_done && !op_we && !err_q) ? ld_data : 32'h0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'h0;
        mem_be    = 4'b0000;
        mem_wdata = 32'h0;
        if (state == S_REQ0) begin
            mem_req   = 1'b1;
            mem_we    = op_we;
            mem_addr  = word0;
            mem_be    = be0;
            mem_wdata = op_we ? wd0 : 32'h0;
        end else if (state == S_REQ1) begin
            mem_req   = 1'b1;
            mem_we    = op_we;
            mem_addr  = word0 + 32'd4;
            mem_be    = be1;
            mem_wdata = op_we ? wd1 : 32'h0;
        end
    end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning the maximum cycles spent waiting for mem_gnt or mem_rvalid before the operation aborts.
REQ-002 SHALL have one clock and a synchronous, active-high reset.
REQ-003 SHALL have port clk  input  1  clock; all logic on posedge.
REQ-004 SHALL have port reset  input  1  synchronous active-high reset.
REQ-005 SHALL have core-side ports:
- lsu_valid  input  1  operation request.
- lsu_ready  output  1  high only in IDLE.
- lsu_we  input  1  1=store, 0=load.
- lsu_type  input  3  funct3 code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- lsu_addr  input  32  byte address.
- lsu_wdata  input  32  store data, right-aligned.
REQ-006 SHALL have core-side result ports:
- lsu_done  output  1  one-cycle completion pulse.
- lsu_rdata  output  32  extended load result, valid with lsu_done.
- lsu_err  output  1  valid with lsu_done; set on illegal type or timeout.
REQ-007 SHALL have memory-side ports:
- mem_req  output  1  request.
- mem_gnt  input  1  request accepted this cycle.
- mem_we  output  1  write.
- mem_addr  output  32  word-aligned address, bits[1:0]=0.
- mem_be  output  4  byte enables, bit i = byte lane i, little-endian.
- mem_wdata  output  32  lane-aligned write data.
- mem_rvalid  input  1  response; ack for stores, data for loads.
- mem_rdata  input  32  read word.

Function
REQ-008 SHALL accept an operation when lsu_valid && lsu_ready, latching we, type, addr and wdata.
REQ-009 SHALL use the FSM IDLE, REQ0, WAIT0, REQ1, WAIT1, DONE with these transitions:
- IDLE->REQ0 on accept.
- REQ0->WAIT0 on mem_gnt.
- WAIT0->REQ1 on mem_rvalid if the access is split, else ->DONE.
- REQ1->WAIT1 on mem_gnt.
- WAIT1->DONE on mem_rvalid.
- DONE->IDLE unconditionally.
REQ-010 SHALL assert mem_req only in REQ0/REQ1, holding addr, be, we and wdata stable until mem_gnt.
REQ-011 SHALL split an access into two beats when offset+size>4: H at offset 3, or W at offsets 1-3.
- Beat 0 goes to the addr[31:2] word, beat 1 to the next word (+4, wrapping modulo 2^32).
REQ-012 SHALL generate byte enables and write data by shifting left by offset:
- Beat 0 gets the lanes offset..min(3, offset+size-1).
- Beat 1 gets the remaining bytes in lanes 0.., with unused lanes' data 0.
REQ-013 SHALL assemble loads from beat-0 bytes (from lane offset) then beat-1 bytes.
- B/H sign-extend from bit 7/15; BU/HU zero-extend; W passes through.
REQ-014 SHALL pulse lsu_done in DONE, with lsu_rdata/lsu_err valid for that cycle only; for stores lsu_rdata=0.
REQ-015 SHALL treat an illegal lsu_type (011, 110, 111) as follows:
- No bus activity.
- IDLE->DONE with lsu_err=1, lsu_rdata=0.
REQ-016 SHALL count wait cycles per beat from entering REQx, restarting for each beat.
- At TIMEOUT cycles without the awaited gnt/rvalid, go to DONE with lsu_err=1 and deassert mem_req.
REQ-017 SHALL ignore mem_rvalid outside WAIT0/WAIT1 and mem_gnt outside REQ0/REQ1.
REQ-018 SHALL ignore lsu_valid while busy; there is no queueing.

Reset
REQ-019 SHALL on reset, including mid-operation, enter IDLE on the next edge with all outputs 0 except lsu_ready=1.
REQ-020 SHALL have no reset latency: the cycle after reset deasserts, an operation is accepted.

Structure
REQ-021 SHALL place the lsu_type encodings and the FSM state enum in the shared package lsu_pkg.
REQ-022 SHALL implement lane shifting, byte enables and load extension in the combinational sub-module lsu_align, instantiated once.

Verification
REQ-023 The bench SHALL preload memory word 0x10=0xDDCCBBAA and word 0x14=0x44332211, with a responder giving gnt immediately and rvalid one cycle later.
REQ-024 SHALL cover loads:
- LB 0x13 -> rdata 0xFFFFFFDD, one beat.
- LBU 0x13 -> 0x000000DD.
- LW 0x10 -> done 3 cycles after accept.
REQ-025 SHALL cover split loads:
- LH 0x13 -> beats at 0x10 then 0x14, rdata 0x000011DD.
- LW 0x12 -> rdata 0x2211DDCC.
REQ-026 SHALL cover stores:
- SW 0xA1B2C3D4 at 0x11 -> beat0 addr 0x10 be 1110 wdata 0xB2C3D400; beat1 addr 0x14 be 0001 wdata 0x000000A1.
- SB 0x5A at 0x16 -> addr 0x14 be 0100 wdata 0x005A0000.
REQ-027 SHALL cover errors:
- lsu_type 011 -> done+err next cycle, mem_req never asserted.
- gnt held low 16 cycles -> done+err, mem_req drops.
REQ-028 SHALL cover reset asserted in WAIT1 of a split LW -> IDLE next cycle, no lsu_done, a new LB accepted immediately after.
